// File: rtl/bster_pkg.sv
// Shared definitions for the bster tree engine and its RAM adapter:
// adapter FSM states, AXI4 encodings and the request/response field layout.
package bster_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } bster_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Default tree-node geometry: one RAM word per node.
  localparam int unsigned BSTER_DATA_W = 32;
  localparam int unsigned BSTER_ADDR_W = 16;

  typedef struct packed {
    logic                    wr;
    logic [BSTER_ADDR_W-1:0] addr;
    logic [BSTER_DATA_W-1:0] wdata;
  } bster_req_t;

  typedef struct packed {
    logic [BSTER_DATA_W-1:0] rdata;
    logic                    err;
  } bster_rsp_t;

  // EXOKAY counts as success; only SLVERR and DECERR are failures.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/bster_ram_if.sv
// Single-outstanding AXI4 master that turns one-word tree-node read/write
// requests into single-beat AXI4 transactions and returns data plus error.
module bster_ram_if
  import bster_pkg::*;
#(
  parameter int unsigned RAM_DATA_WIDTH = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 16,
  parameter int unsigned RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
  parameter int unsigned RAM_ID_WIDTH   = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req_wdata,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RAM_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,

  output logic [RAM_ID_WIDTH-1:0]   ram_axi_awid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_axi_awaddr,
  output logic [7:0]                ram_axi_awlen,
  output logic [2:0]                ram_axi_awsize,
  output logic [1:0]                ram_axi_awburst,
  output logic                      ram_axi_awlock,
  output logic [3:0]                ram_axi_awcache,
  output logic [2:0]                ram_axi_awprot,
  output logic [3:0]                ram_axi_awqos,
  output logic [3:0]                ram_axi_awregion,
  output logic                      ram_axi_awvalid,
  input  logic                      ram_axi_awready,

  output logic [RAM_DATA_WIDTH-1:0] ram_axi_wdata,
  output logic [RAM_STRB_WIDTH-1:0] ram_axi_wstrb,
  output logic                      ram_axi_wlast,
  output logic                      ram_axi_wvalid,
  input  logic                      ram_axi_wready,

  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_bid,
  input  logic [1:0]                ram_axi_bresp,
  input  logic                      ram_axi_bvalid,
  output logic                      ram_axi_bready,

  output logic [RAM_ID_WIDTH-1:0]   ram_axi_arid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_axi_araddr,
  output logic [7:0]                ram_axi_arlen,
  output logic [2:0]                ram_axi_arsize,
  output logic [1:0]                ram_axi_arburst,
  output logic                      ram_axi_arlock,
  output logic [3:0]                ram_axi_arcache,
  output logic [2:0]                ram_axi_arprot,
  output logic [3:0]                ram_axi_arqos,
  output logic [3:0]                ram_axi_arregion,
  output logic                      ram_axi_arvalid,
  input  logic                      ram_axi_arready,

  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_rid,
  input  logic [RAM_DATA_WIDTH-1:0] ram_axi_rdata,
  input  logic [1:0]                ram_axi_rresp,
  input  logic                      ram_axi_rlast,
  input  logic                      ram_axi_rvalid,
  output logic                      ram_axi_rready
);

  localparam int unsigned ADDR_LSB = $clog2(RAM_STRB_WIDTH);
  localparam logic [2:0] AXI_SIZE = 3'(ADDR_LSB);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_MASK = ~RAM_ADDR_WIDTH'(RAM_STRB_WIDTH - 1);

  bster_state_e              state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [RAM_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q && ram_axi_awready;
  assign w_hs  = wvalid_q && ram_axi_wready;

  // The only unregistered output: gated by aresetn so it is low during reset.
  assign req_ready = aresetn && (state_q == S_IDLE);

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value before
    // the case, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr & ADDR_MASK;
          wdata_d = req_wdata;
          if (req_wr) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      S_WR: begin
        // AW and W complete independently; either may finish first.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (ram_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = resp_is_err(ram_axi_bresp) || (ram_axi_bid != '0);
          state_d     = S_RESP;
        end
      end

      S_RD_ADDR: begin
        if (ram_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (ram_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_axi_rdata;
          rsp_err_d   = resp_is_err(ram_axi_rresp) || (ram_axi_rid != '0) || !ram_axi_rlast;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      // NOTE: payload registers are reset as well; they are a handful of
      // flops (not a memory array) and this keeps the bus payload defined.
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign ram_axi_awid     = '0;
  assign ram_axi_awaddr   = addr_q;
  assign ram_axi_awlen    = 8'd0;
  assign ram_axi_awsize   = AXI_SIZE;
  assign ram_axi_awburst  = BURST_INCR;
  assign ram_axi_awlock   = 1'b0;
  assign ram_axi_awcache  = 4'b0000;
  assign ram_axi_awprot   = 3'b000;
  assign ram_axi_awqos    = 4'b0000;
  assign ram_axi_awregion = 4'b0000;
  assign ram_axi_awvalid  = awvalid_q;

  assign ram_axi_wdata  = wdata_q;
  assign ram_axi_wstrb  = '1;
  assign ram_axi_wlast  = wvalid_q;
  assign ram_axi_wvalid = wvalid_q;

  assign ram_axi_bready = bready_q;

  assign ram_axi_arid     = '0;
  assign ram_axi_araddr   = addr_q;
  assign ram_axi_arlen    = 8'd0;
  assign ram_axi_arsize   = AXI_SIZE;
  assign ram_axi_arburst  = BURST_INCR;
  assign ram_axi_arlock   = 1'b0;
  assign ram_axi_arcache  = 4'b0000;
  assign ram_axi_arprot   = 3'b000;
  assign ram_axi_arqos    = 4'b0000;
  assign ram_axi_arregion = 4'b0000;
  assign ram_axi_arvalid  = arvalid_q;

  assign ram_axi_rready = rready_q;

endmodule

// File: tb/tb_bster_ram_if.sv
// Directed bench for bster_ram_if: a configurable AXI slave, a transaction-level
// reference model checked every cycle, and hand-computed expectations per scenario.
module tb_bster_ram_if;

  logic        clk, aresetn;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic [7:0]  awid, awlen;
  logic [15:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic        awlock, awvalid, awready;
  logic [3:0]  awcache, awqos, awregion;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  arid, arlen;
  logic [15:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock, arvalid, arready;
  logic [3:0]  arcache, arqos, arregion;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  bster_ram_if dut (
    .aclk(clk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_axi_awid(awid), .ram_axi_awaddr(awaddr), .ram_axi_awlen(awlen),
    .ram_axi_awsize(awsize), .ram_axi_awburst(awburst), .ram_axi_awlock(awlock),
    .ram_axi_awcache(awcache), .ram_axi_awprot(awprot), .ram_axi_awqos(awqos),
    .ram_axi_awregion(awregion), .ram_axi_awvalid(awvalid), .ram_axi_awready(awready),
    .ram_axi_wdata(wdata), .ram_axi_wstrb(wstrb), .ram_axi_wlast(wlast),
    .ram_axi_wvalid(wvalid), .ram_axi_wready(wready),
    .ram_axi_bid(bid), .ram_axi_bresp(bresp), .ram_axi_bvalid(bvalid), .ram_axi_bready(bready),
    .ram_axi_arid(arid), .ram_axi_araddr(araddr), .ram_axi_arlen(arlen),
    .ram_axi_arsize(arsize), .ram_axi_arburst(arburst), .ram_axi_arlock(arlock),
    .ram_axi_arcache(arcache), .ram_axi_arprot(arprot), .ram_axi_arqos(arqos),
    .ram_axi_arregion(arregion), .ram_axi_arvalid(arvalid), .ram_axi_arready(arready),
    .ram_axi_rid(rid), .ram_axi_rdata(rdata), .ram_axi_rresp(rresp), .ram_axi_rlast(rlast),
    .ram_axi_rvalid(rvalid), .ram_axi_rready(rready)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- AXI slave with per-test knobs ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  k_bresp = 2'b00, k_rresp = 2'b00;
  logic [7:0]  k_bid = 8'h00, k_rid = 8'h00;
  logic [31:0] k_rdata = 32'h0;
  logic        k_rlast = 1'b1;

  int   aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic got_aw, got_w, got_ar;
  logic p_aw, p_w, p_ar, p_b, p_r;

  initial begin
    {awready, wready, arready, bvalid, rvalid} = '0;
    {bid, bresp, rid, rdata, rresp, rlast} = '0;
    {got_aw, got_w, got_ar, p_aw, p_w, p_ar, p_b, p_r} = '0;
    {aw_cnt, w_cnt, ar_cnt, r_cnt} = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        {awready, wready, arready, bvalid, rvalid} = '0;
        {got_aw, got_w, got_ar, p_aw, p_w, p_ar, p_b, p_r} = '0;
        {aw_cnt, w_cnt, ar_cnt, r_cnt} = '0;
      end else begin
        // p_* hold the handshakes that happened at the preceding rising edge.
        if (p_b) begin got_aw = 1'b0; got_w = 1'b0; end
        if (p_r) got_ar = 1'b0;
        if (p_aw) got_aw = 1'b1;
        if (p_w)  got_w  = 1'b1;
        if (p_ar) got_ar = 1'b1;
        awready = awvalid && (aw_cnt >= aw_delay);
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_delay);
        w_cnt   = wvalid ? w_cnt + 1 : 0;
        arready = arvalid && (ar_cnt >= ar_delay);
        ar_cnt  = arvalid ? ar_cnt + 1 : 0;
        bvalid  = got_aw && got_w;
        bid     = k_bid;
        bresp   = k_bresp;
        rvalid  = got_ar && (r_cnt >= r_delay);
        r_cnt   = got_ar ? r_cnt + 1 : 0;
        rid     = k_rid;
        rdata   = k_rdata;
        rresp   = k_rresp;
        rlast   = k_rlast;
        p_aw = awvalid && awready;
        p_w  = wvalid && wready;
        p_ar = arvalid && arready;
        p_b  = bvalid && bready;
        p_r  = rvalid && rready;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  // One transaction at a time, tracked as pending phases; checked 1 time unit
  // before each rising edge, when all inputs and outputs are settled.
  logic        m_busy = 0, m_wr = 0, m_aw = 0, m_w = 0, m_ar = 0, m_b = 0, m_r = 0, m_rsp = 0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  logic        m_err = 0;

  initial forever begin
    @(negedge clk);
    #4;
    if (!aresetn) begin
      check("mon_reset_outputs",
            {awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready, rsp_err, rsp_rdata}, '0);
      {m_busy, m_wr, m_aw, m_w, m_ar, m_b, m_r, m_rsp} = '0;
    end else begin
      check("mon_req_ready", req_ready, !m_busy);
      check("mon_awvalid", awvalid, m_aw);
      check("mon_wvalid", wvalid, m_w);
      check("mon_arvalid", arvalid, m_ar);
      check("mon_bready", bready, m_b);
      check("mon_rready", rready, m_r);
      check("mon_rsp_valid", rsp_valid, m_rsp);
      if (m_aw)
        check("mon_aw_payload",
              {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion},
              {8'h00, m_addr & 16'hFFFC, 8'h00, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0});
      if (m_w)
        check("mon_w_payload", {wdata, wstrb, wlast}, {m_wdata, 4'hF, 1'b1});
      if (m_ar)
        check("mon_ar_payload",
              {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion},
              {8'h00, m_addr & 16'hFFFC, 8'h00, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0});
      if (m_rsp)
        check("mon_rsp_payload", {rsp_err, rsp_rdata}, {m_err, m_rdata});

      if (m_rsp) begin
        if (rsp_ready) begin m_rsp = 0; m_busy = 0; end
      end else if (m_b) begin
        if (bvalid) begin
          m_b = 0; m_rsp = 1; m_rdata = '0;
          m_err = bresp[1] || (bid != 0);
        end
      end else if (m_r) begin
        if (rvalid) begin
          m_r = 0; m_rsp = 1; m_rdata = rdata;
          m_err = rresp[1] || (rid != 0) || !rlast;
        end
      end else if (m_aw || m_w) begin
        if (m_aw && awready) m_aw = 0;
        if (m_w && wready) m_w = 0;
        if (!m_aw && !m_w) m_b = 1;
      end else if (m_ar) begin
        if (arready) begin m_ar = 0; m_r = 1; end
      end else if (!m_busy && req_valid) begin
        m_busy = 1; m_wr = req_wr; m_addr = req_addr; m_wdata = req_wdata;
        if (req_wr) begin m_aw = 1; m_w = 1; end
        else m_ar = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic wr, input logic [15:0] a, input logic [31:0] d, output int c0);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_accept_timeout", (n < 50), 1'b1);
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_rsp(input string name, input int c0, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check({name, "_timeout"}, (n < 50), 1'b1);
    if (lat >= 0) check({name, "_latency"}, cyc - c0, lat);
    check({name, "_rdata"}, rsp_rdata, exp_rdata);
    check({name, "_err"}, rsp_err, exp_err);
    @(negedge clk);
    check({name, "_req_ready_next"}, req_ready, 1'b1);
  endtask

  task automatic txn(input string name, input logic wr, input logic [15:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rdata, input logic exp_err);
    int c0;
    send(wr, a, d, c0);
    wait_rsp(name, c0, 3, exp_rdata, exp_err);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0;
    aresetn = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready, rsp_err, rsp_rdata}, '0);
    aresetn = 1'b1;
    #1 check("req_ready_after_reset", req_ready, 1'b1);

    // Write, slave always ready.
    send(1'b1, 16'h0010, 32'hDEADBEEF, c0);
    check("wr_c1_valids", {awvalid, wvalid}, 2'b11);
    check("wr_c1_awaddr", awaddr, 16'h0010);
    check("wr_c1_wdata", wdata, 32'hDEADBEEF);
    check("wr_c1_wstrb_wlast", {wstrb, wlast}, 5'b11111);
    @(negedge clk);
    check("wr_c2_bready", {awvalid, wvalid, bready}, 3'b001);
    wait_rsp("wr_best", c0, 3, 32'h0, 1'b0);

    // Unaligned write address is forced to a word boundary.
    send(1'b1, 16'h0017, 32'h0BB00BB0, c0);
    check("wr_unaligned_awaddr", awaddr, 16'h0014);
    wait_rsp("wr_unaligned", c0, 3, 32'h0, 1'b0);

    // Read with arready delayed 3 cycles.
    ar_delay = 3; k_rdata = 32'h12345678;
    send(1'b0, 16'h0013, 32'h0, c0);
    for (int i = 1; i <= 4; i++) begin
      check("rd_slow_arvalid", arvalid, 1'b1);
      check("rd_slow_araddr", araddr, 16'h0010);
      @(negedge clk);
    end
    check("rd_slow_c5", {arvalid, rready}, 2'b01);
    wait_rsp("rd_slow", c0, 6, 32'h12345678, 1'b0);
    ar_delay = 0;

    // Skewed write channels: AW in cycle 1, W in cycle 4.
    w_delay = 3;
    send(1'b1, 16'h0020, 32'hA5A50001, c0);
    check("skew_c1", {awvalid, wvalid, bready}, 3'b110);
    @(negedge clk);
    check("skew_c2", {awvalid, wvalid, bready}, 3'b010);
    @(negedge clk);
    @(negedge clk);
    check("skew_c4", {awvalid, wvalid, bready}, 3'b010);
    @(negedge clk);
    check("skew_c5", {awvalid, wvalid, bready}, 3'b001);
    wait_rsp("skew", c0, 6, 32'h0, 1'b0);
    w_delay = 0;

    // Error and success response codes.
    k_bresp = 2'b10; txn("wr_slverr", 1'b1, 16'h0100, 32'h1, 32'h0, 1'b1);
    k_bresp = 2'b01; txn("wr_exokay", 1'b1, 16'h0104, 32'h2, 32'h0, 1'b0);
    k_bresp = 2'b00;
    k_bid = 8'h01; txn("wr_bid", 1'b1, 16'h0108, 32'h3, 32'h0, 1'b1);
    k_bid = 8'h00;
    k_rdata = 32'h55AA55AA;
    k_rlast = 1'b0; txn("rd_rlast_low", 1'b0, 16'h0200, 32'h0, 32'h55AA55AA, 1'b1);
    k_rlast = 1'b1;
    k_rid = 8'h01; txn("rd_rid", 1'b0, 16'h0204, 32'h0, 32'h55AA55AA, 1'b1);
    k_rid = 8'h00;
    k_rresp = 2'b01; txn("rd_exokay", 1'b0, 16'h0208, 32'h0, 32'h55AA55AA, 1'b0);
    k_rresp = 2'b11; txn("rd_decerr", 1'b0, 16'h020C, 32'h0, 32'h55AA55AA, 1'b1);
    k_rresp = 2'b00;

    // Response backpressure with a new request waiting.
    rsp_ready = 1'b0; k_rdata = 32'h0BADCAFE;
    send(1'b0, 16'h0050, 32'h0, c0);
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      check("bp_timeout", (n < 50), 1'b1);
    end
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0060; req_wdata = 32'h11112222;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BADCAFE});
      check("bp_quiet", {req_ready, awvalid, wvalid, arvalid}, 4'b0000);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {req_ready, rsp_valid}, 2'b10);
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    check("bp_next_aw", {awvalid, awaddr}, {1'b1, 16'h0060});
    wait_rsp("bp_next", c0, 3, 32'h0, 1'b0);

    // Reset while waiting in RD_DATA.
    r_delay = 5;
    send(1'b0, 16'h0040, 32'h0, c0);
    @(negedge clk);
    check("rst_pre_rready", rready, 1'b1);
    aresetn = 1'b0;
    #1 check("rst_async_outputs",
             {awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready}, 7'b0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1; r_delay = 0; k_rdata = 32'hCAFEF00D;
    #1 check("rst_release_req_ready", req_ready, 1'b1);
    txn("rd_after_rst", 1'b0, 16'h0044, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
